det2x2_fetch_controller: RTL

//  FSM sequencer for the 2x2 determinant datapath: fetches matrix elements a,b,c,d from a sync-read memory
//  at base_addr..base_addr+3, then steps the datapath through p1=a*d, p2=b*c and res=p1-p2.

---
 rtl/det2x2_fetch_controller.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/det2x2_fetch_controller.sv
// Control sequencer for the 2x2 determinant datapath: fetches a,b,c,d from a sync-read memory,
// then steps the datapath through a*d, b*c and their difference. Optional abort input: `define DET_ABORT_EN.
module det2x2_fetch_controller #(
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
`ifdef DET_ABORT_EN
  input  logic              abort,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              ld_a,
  output logic              ld_b,
  output logic              ld_c,
  output logic              ld_d,
  output logic              ld_p1,
  output logic              ld_p2,
  output logic              ld_res,
  output logic              sel_sub,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_MUL1, S_MUL2, S_SUB, S_DONE
  } state_t;

  state_t            state;
  logic [1:0]        cnt;
  logic [1:0]        cnt_inc;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] addr_inc;

  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_rd_q, ld_a_q, ld_b_q, ld_c_q, ld_d_q;
  logic              ld_p1_q, ld_p2_q, ld_res_q, sel_sub_q, busy_q, done_q;

  assign cnt_inc  = cnt + 2'd1;
  assign addr_inc = base_q + ADDR_W'(cnt_inc);

  // Outputs are registered from the next state, so each one is a clean Moore decode of state/cnt.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= 2'd0;
      base_q     <= '0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      ld_a_q     <= 1'b0;
      ld_b_q     <= 1'b0;
      ld_c_q     <= 1'b0;
      ld_d_q     <= 1'b0;
      ld_p1_q    <= 1'b0;
      ld_p2_q    <= 1'b0;
      ld_res_q   <= 1'b0;
      sel_sub_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      mem_rd_q  <= 1'b0;
      ld_a_q    <= 1'b0;
      ld_b_q    <= 1'b0;
      ld_c_q    <= 1'b0;
      ld_d_q    <= 1'b0;
      ld_p1_q   <= 1'b0;
      ld_p2_q   <= 1'b0;
      ld_res_q  <= 1'b0;
      sel_sub_q <= 1'b0;
      done_q    <= 1'b0;
      case (state)
        // DONE accepts a held start directly so back-to-back runs keep a 9-cycle period.
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_FETCH;
            cnt        <= 2'd0;
            base_q     <= base_addr;
            mem_addr_q <= base_addr;
            mem_rd_q   <= 1'b1;
            busy_q     <= 1'b1;
          end else begin
            state      <= S_IDLE;
            cnt        <= 2'd0;
            mem_addr_q <= base_q;
            busy_q     <= 1'b0;
          end
        end
        S_FETCH: begin
          cnt <= cnt_inc;
          if (cnt != 2'd3) begin
            mem_addr_q <= addr_inc;
            mem_rd_q   <= 1'b1;
            ld_a_q     <= (cnt_inc == 2'd1);
            ld_b_q     <= (cnt_inc == 2'd2);
            ld_c_q     <= (cnt_inc == 2'd3);
          end else begin
            // Last read was issued at cnt 3; its data lands in d during WAIT.
            state      <= S_WAIT;
            mem_addr_q <= base_q;
            ld_d_q     <= 1'b1;
          end
        end
        S_WAIT: begin
          state   <= S_MUL1;
          ld_p1_q <= 1'b1;
        end
        S_MUL1: begin
          state   <= S_MUL2;
          ld_p2_q <= 1'b1;
        end
        S_MUL2: begin
          state     <= S_SUB;
          ld_res_q  <= 1'b1;
          sel_sub_q <= 1'b1;
        end
        S_SUB: begin
          state  <= S_DONE;
          done_q <= 1'b1;
        end
        default: begin
          state  <= S_IDLE;
          cnt    <= 2'd0;
          busy_q <= 1'b0;
        end
      endcase
`ifdef DET_ABORT_EN
      if (abort && state != S_IDLE) begin
        state      <= S_IDLE;
        cnt        <= 2'd0;
        mem_addr_q <= base_q;
        mem_rd_q   <= 1'b0;
        ld_a_q     <= 1'b0;
        ld_b_q     <= 1'b0;
        ld_c_q     <= 1'b0;
        ld_d_q     <= 1'b0;
        ld_p1_q    <= 1'b0;
        ld_p2_q    <= 1'b0;
        ld_res_q   <= 1'b0;
        sel_sub_q  <= 1'b0;
        done_q     <= 1'b0;
        busy_q     <= 1'b0;
      end
`endif
    end
  end

`ifdef DET_ABORT_EN
  // An abort must suppress the strobes in the very cycle it is raised, not just from the next edge.
  logic kill;
  assign kill   = abort & busy_q;
  assign mem_rd = mem_rd_q & ~kill;
  assign ld_a   = ld_a_q   & ~kill;
  assign ld_b   = ld_b_q   & ~kill;
  assign ld_c   = ld_c_q   & ~kill;
  assign ld_d   = ld_d_q   & ~kill;
  assign ld_p1  = ld_p1_q  & ~kill;
  assign ld_p2  = ld_p2_q  & ~kill;
  assign ld_res = ld_res_q & ~kill;
  assign done   = done_q   & ~kill;
`else
  assign mem_rd = mem_rd_q;
  assign ld_a   = ld_a_q;
  assign ld_b   = ld_b_q;
  assign ld_c   = ld_c_q;
  assign ld_d   = ld_d_q;
  assign ld_p1  = ld_p1_q;
  assign ld_p2  = ld_p2_q;
  assign ld_res = ld_res_q;
  assign done   = done_q;
`endif

  assign mem_addr = mem_addr_q;
  assign sel_sub  = sel_sub_q;
  assign busy     = busy_q;

endmodule
